mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_stage_data_ram.sv | 24 ++
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared size encodings, widths and alignment helper for the MEM stage
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int RN_W   = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 11 is reserved and therefore never a legal access.
  function automatic logic illegal_access(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return |lane;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// rtl/mem_stage_data_ram.sv - byte-enable synchronous-write, asynchronous-read data RAM
module data_ram
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: sized loads/stores and the MEM/WB register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic              ex_wmem,
  input  logic              ex_rmem,
  input  logic [1:0]        ex_size,
  input  logic              ex_sext,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_b,
  input  logic [RN_W-1:0]   ex_rn,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_wreg,
  output logic              wb_m2reg,
  output logic [DATA_W-1:0] wb_alu,
  output logic [DATA_W-1:0] wb_mo,
  output logic [RN_W-1:0]   wb_d,
  output logic              align_err
);

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              bad;
  logic [3:0]        ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  logic              wreg_q, wreg_d;
  logic              m2reg_q, m2reg_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mo_q, mo_d;
  logic [RN_W-1:0]   d_q, d_d;
  logic              err_q, err_d;

  assign word_idx = ex_alu[ADDR_W+1:2];
  assign lane     = ex_alu[1:0];
  assign bad      = illegal_access(ex_size, lane) & (ex_wmem | ex_rmem);

  // Replicating the store data lets the byte enables alone pick the lanes.
  always_comb begin
    ram_we    = 4'b0000;
    ram_wdata = ex_b;
    case (ex_size)
      SZ_BYTE: begin
        ram_we    = 4'b0001 << lane;
        ram_wdata = {4{ex_b[7:0]}};
      end
      SZ_HALF: begin
        ram_we    = lane[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{ex_b[15:0]}};
      end
      SZ_WORD: ram_we = 4'b1111;
      default: ram_we = 4'b0000;
    endcase
    if (!(ex_wmem && !stall && !flush && clrn && !bad)) ram_we = 4'b0000;
  end

  data_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (word_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    ld_byte = ram_rdata[7:0];
    case (lane)
      2'd0: ld_byte = ram_rdata[7:0];
      2'd1: ld_byte = ram_rdata[15:8];
      2'd2: ld_byte = ram_rdata[23:16];
      2'd3: ld_byte = ram_rdata[31:24];
      default: ld_byte = ram_rdata[7:0];
    endcase
    ld_half = lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (ex_size)
      SZ_BYTE: ld_ext = {{24{ex_sext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{16{ex_sext & ld_half[15]}}, ld_half};
      default: ld_ext = ram_rdata;
    endcase
  end

  always_comb begin
    wreg_d  = wreg_q;
    m2reg_d = m2reg_q;
    alu_d   = alu_q;
    mo_d    = mo_q;
    d_d     = d_q;
    err_d   = err_q;
    if (flush) begin
      wreg_d  = 1'b0;
      m2reg_d = 1'b0;
      alu_d   = '0;
      mo_d    = '0;
      d_d     = '0;
      err_d   = 1'b0;
    end else if (!stall) begin
      wreg_d  = ex_wreg & ~bad;
      m2reg_d = ex_m2reg;
      alu_d   = ex_alu;
      mo_d    = (ex_rmem && !bad) ? ld_ext : '0;
      d_d     = ex_rn;
      err_d   = bad;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      alu_q   <= '0;
      mo_q    <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      wreg_q  <= wreg_d;
      m2reg_q <= m2reg_d;
      alu_q   <= alu_d;
      mo_q    <= mo_d;
      d_q     <= d_d;
      err_q   <= err_d;
    end
  end

  assign wb_wreg   = wreg_q;
  assign wb_m2reg  = m2reg_q;
  assign wb_alu    = alu_q;
  assign wb_mo     = mo_q;
  assign wb_d      = d_q;
  assign align_err = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized checks of mem_stage against a byte-array model
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_rmem, ex_sext;
  logic [1:0]  ex_size;
  logic [31:0] ex_alu, ex_b;
  logic [4:0]  ex_rn;
  logic        stall, flush;
  logic        wb_wreg, wb_m2reg, align_err;
  logic [31:0] wb_alu, wb_mo;
  logic [4:0]  wb_d;

  int total = 0;
  int bad_cnt = 0;

  logic [7:0]  ref_mem [64];
  logic        e_wreg, e_m2reg, e_err;
  logic [31:0] e_alu, e_mo;
  logic [4:0]  e_d;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(10)) dut (
    .clk(clk), .clrn(clrn),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem), .ex_rmem(ex_rmem),
    .ex_size(ex_size), .ex_sext(ex_sext), .ex_alu(ex_alu), .ex_b(ex_b), .ex_rn(ex_rn),
    .stall(stall), .flush(flush),
    .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg), .wb_alu(wb_alu), .wb_mo(wb_mo),
    .wb_d(wb_d), .align_err(align_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_wreg"},  {31'd0, wb_wreg},   {31'd0, e_wreg});
    chk({tag, "_m2reg"}, {31'd0, wb_m2reg},  {31'd0, e_m2reg});
    chk({tag, "_alu"},   wb_alu,             e_alu);
    chk({tag, "_mo"},    wb_mo,              e_mo);
    chk({tag, "_d"},     {27'd0, wb_d},      {27'd0, e_d});
    chk({tag, "_err"},   {31'd0, align_err}, {31'd0, e_err});
  endtask

  function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a, input logic w, input logic r);
    logic ill;
    ill = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    return ill && (w || r);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a, input logic sx);
    int p;
    logic [31:0] v;
    p = int'(a[5:0]);
    if (sz == 2'b00) begin
      v = {24'd0, ref_mem[p]};
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = {16'd0, ref_mem[p+1], ref_mem[p]};
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = {ref_mem[p+3], ref_mem[p+2], ref_mem[p+1], ref_mem[p]};
    end
    return v;
  endfunction

  task automatic model_edge();
    logic b;
    int p;
    b = is_bad(ex_size, ex_alu, ex_wmem, ex_rmem);
    p = int'(ex_alu[5:0]);
    if (flush) begin
      {e_wreg, e_m2reg, e_err} = 3'b000;
      e_alu = 0; e_mo = 0; e_d = 0;
    end else if (!stall) begin
      e_wreg  = ex_wreg && !b;
      e_m2reg = ex_m2reg;
      e_alu   = ex_alu;
      e_d     = ex_rn;
      e_err   = b;
      e_mo    = (ex_rmem && !b) ? ref_load(ex_size, ex_alu, ex_sext) : 32'd0;
    end
    if (ex_wmem && !stall && !flush && !b) begin
      if (ex_size == 2'b00) ref_mem[p] = ex_b[7:0];
      else if (ex_size == 2'b01) begin
        ref_mem[p] = ex_b[7:0]; ref_mem[p+1] = ex_b[15:8];
      end else begin
        for (int k = 0; k < 4; k++) ref_mem[p+k] = ex_b[8*k +: 8];
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic drive(input logic w, input logic r, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] bv, input logic wr,
                       input logic m2, input logic [4:0] rn, input logic st, input logic fl);
    ex_wmem = w; ex_rmem = r; ex_size = sz; ex_sext = sx; ex_alu = a; ex_b = bv;
    ex_wreg = wr; ex_m2reg = m2; ex_rn = rn; stall = st; flush = fl;
  endtask

  initial begin
    logic [31:0] rv;
    logic [1:0]  sz;
    logic        w, r;
    clrn = 1'b0;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    {e_wreg, e_m2reg, e_err} = 3'b000;
    e_alu = 0; e_mo = 0; e_d = 0;
    #2;
    chk_all("reset");
    @(posedge clk); #1;
    clrn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 2'b10, 0, 32'(i * 4), $urandom, 0, 0, 0, 0, 0);
      tick("preload");
    end

    drive(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 5'd3, 0, 0);
    tick("st_word");
    drive(0, 1, 2'b10, 0, 32'h10, 0, 1, 1, 5'd9, 0, 0);
    tick("ld_word");
    chk("tp_word", wb_mo, 32'hDEADBEEF);
    drive(0, 1, 2'b00, 1, 32'h13, 0, 1, 1, 5'd4, 0, 0);
    tick("ld_byte_s");
    chk("tp_byte_s", wb_mo, 32'hFFFFFFDE);
    drive(0, 1, 2'b00, 0, 32'h13, 0, 1, 1, 5'd4, 0, 0);
    tick("ld_byte_u");
    chk("tp_byte_u", wb_mo, 32'h000000DE);
    drive(1, 0, 2'b01, 0, 32'h12, 32'h5555_1234, 0, 0, 0, 0, 0);
    tick("st_half");
    drive(0, 1, 2'b10, 0, 32'h10, 0, 1, 1, 5'd5, 0, 0);
    tick("ld_merged");
    chk("tp_merged", wb_mo, 32'h1234BEEF);
    drive(0, 1, 2'b01, 0, 32'h11, 0, 1, 1, 5'd6, 0, 0);
    tick("ld_misal");
    chk("tp_misal_err", {31'd0, align_err}, 32'd1);
    chk("tp_misal_wreg", {31'd0, wb_wreg}, 32'd0);
    drive(1, 0, 2'b01, 0, 32'h11, 32'hFFFF, 0, 0, 0, 0, 0);
    tick("st_misal");
    drive(0, 1, 2'b10, 0, 32'h10, 0, 1, 1, 5'd5, 0, 0);
    tick("ld_after_misal");
    chk("tp_unchanged", wb_mo, 32'h1234BEEF);

    drive(1, 0, 2'b10, 0, 32'h24, 32'hCAFEF00D, 0, 0, 0, 1, 0);
    tick("stall_a1");
    tick("stall_a2");
    drive(0, 1, 2'b10, 0, 32'h24, 0, 1, 1, 5'd2, 0, 0);
    tick("ld_after_stall");
    drive(1, 0, 2'b10, 0, 32'h20, 32'h0BADF00D, 0, 0, 0, 1, 0);
    tick("stall_b1");
    tick("stall_b2");
    stall = 0;
    tick("stall_rel");
    drive(0, 1, 2'b10, 0, 32'h20, 0, 1, 1, 5'd8, 0, 0);
    tick("ld_released");
    chk("tp_released", wb_mo, 32'h0BADF00D);

    drive(0, 1, 2'b10, 0, 32'h20, 0, 1, 1, 5'd8, 1, 1);
    tick("flush_ld");
    chk("tp_flush_wreg", {31'd0, wb_wreg}, 32'd0);
    drive(1, 0, 2'b10, 0, 32'h20, 32'h1111_2222, 0, 0, 0, 0, 1);
    tick("flush_st");
    drive(0, 1, 2'b10, 0, 32'h20, 0, 1, 1, 5'd8, 0, 0);
    tick("ld_after_flush");
    chk("tp_flush_nowrite", wb_mo, 32'h0BADF00D);

    drive(0, 1, 2'b10, 0, 32'h20, 0, 1, 1, 5'd8, 1, 0);
    #3;
    clrn = 1'b0;
    #1;
    {e_wreg, e_m2reg, e_err} = 3'b000;
    e_alu = 0; e_mo = 0; e_d = 0;
    chk_all("async_rst");
    #2;
    clrn = 1'b1;
    stall = 0;
    tick("ld_after_rst");
    chk("tp_ram_kept", wb_mo, 32'h0BADF00D);

    for (int i = 0; i < 300; i++) begin
      rv = $urandom;
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: begin w = 1; r = 0; end
        1: begin w = 0; r = 1; end
        default: begin w = 0; r = 0; end
      endcase
      drive(w, r, sz, 1'($urandom), {rv[31:12], 6'd0, rv[5:0]}, $urandom, 1'($urandom),
            1'($urandom), 5'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
